// File: rtl/operand_fwd_unit_if.sv
// ---------------------------------------------------------------------------
// operand_fwd_unit_if
// Bundle of every non-clock/reset signal of the operand forwarding unit.
//   slave  : the forwarding unit itself
//   master : the surrounding pipeline (issue, execute, result pipeline, WB)
// Signals:
//   req_valid/req_ready            operand request handshake from issue
//   req_r{a,b,c}_addr [0:6]         source register numbers
//   rf_r{a,b,c}_data  [0:127]       register-file read data for those numbers
//   packed_result_Nstage [0:142]    in-flight result, stage N = 1 (youngest)..7
//                                   [0:2] unit_id, [3:130] result,
//                                   [131:137] reg_dst, [138:141] latency,
//                                   [142] reg_wr
//   wb_addr/wb_data/wb_en           writeback-stage register write
//   out_valid/out_ready             handshake to the execute stage
//   out_r{a,b,c}_data [0:127]       resolved operands
//   hazard                          current request blocked by a producer
//   stall_count [0:15]              saturating count of stalled request cycles
// ---------------------------------------------------------------------------
interface operand_fwd_unit_if;
    logic         req_valid;
    logic         req_ready;
    logic [0:6]   req_ra_addr;
    logic [0:6]   req_rb_addr;
    logic [0:6]   req_rc_addr;
    logic [0:127] rf_ra_data;
    logic [0:127] rf_rb_data;
    logic [0:127] rf_rc_data;
    logic [0:142] packed_result_1stage;
    logic [0:142] packed_result_2stage;
    logic [0:142] packed_result_3stage;
    logic [0:142] packed_result_4stage;
    logic [0:142] packed_result_5stage;
    logic [0:142] packed_result_6stage;
    logic [0:142] packed_result_7stage;
    logic [0:6]   wb_addr;
    logic [0:127] wb_data;
    logic         wb_en;
    logic         out_valid;
    logic         out_ready;
    logic [0:127] out_ra_data;
    logic [0:127] out_rb_data;
    logic [0:127] out_rc_data;
    logic         hazard;
    logic [0:15]  stall_count;

    modport slave (
        input  req_valid, req_ra_addr, req_rb_addr, req_rc_addr,
        input  rf_ra_data, rf_rb_data, rf_rc_data,
        input  packed_result_1stage, packed_result_2stage, packed_result_3stage,
        input  packed_result_4stage, packed_result_5stage, packed_result_6stage,
        input  packed_result_7stage,
        input  wb_addr, wb_data, wb_en, out_ready,
        output req_ready, out_valid, out_ra_data, out_rb_data, out_rc_data,
        output hazard, stall_count
    );

    modport master (
        output req_valid, req_ra_addr, req_rb_addr, req_rc_addr,
        output rf_ra_data, rf_rb_data, rf_rc_data,
        output packed_result_1stage, packed_result_2stage, packed_result_3stage,
        output packed_result_4stage, packed_result_5stage, packed_result_6stage,
        output packed_result_7stage,
        output wb_addr, wb_data, wb_en, out_ready,
        input  req_ready, out_valid, out_ra_data, out_rb_data, out_rc_data,
        input  hazard, stall_count
    );
endinterface

// File: rtl/operand_fwd_unit.sv
// ---------------------------------------------------------------------------
// operand_fwd_unit
// Resolves three source operands against the in-flight result pipeline
// (stages 1..7, youngest first), the writeback port and the register file,
// and hands them to execute through a one-entry output register.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-low reset
//   bus   : operand_fwd_unit_if.slave (request, pipeline, WB, output, status)
// ---------------------------------------------------------------------------
module operand_fwd_unit (
    input  logic                     clk,
    input  logic                     rst,
    operand_fwd_unit_if.slave        bus
);

    typedef enum logic {EMPTY, FULL} state_t;

    // Same bit order as the packed_result ports: unit_id occupies the top bits.
    typedef struct packed {
        logic [2:0]   unit_id;
        logic [127:0] result;
        logic [6:0]   reg_dst;
        logic [3:0]   latency;
        logic         reg_wr;
    } stage_t;

    typedef struct packed {
        logic         blocked;
        logic [127:0] data;
    } operand_t;

    stage_t [7:1] stages;
    operand_t     op_a, op_b, op_c;
    logic         accept;

    state_t       state;
    logic         out_valid_q;
    logic [127:0] ra_q, rb_q, rc_q;
    logic [15:0]  stall_q;

    // Start from the register file, let WB override it, then walk the
    // pipeline oldest to youngest so the youngest matching stage wins. The
    // winner alone decides readiness, so an older ready copy never hides a
    // younger producer that is still computing.
    function automatic operand_t resolve(
        input logic [6:0]    addr,
        input logic [127:0]  rf_data,
        input stage_t [7:1]  st,
        input logic          wb_en,
        input logic [6:0]    wb_addr,
        input logic [127:0]  wb_data
    );
        operand_t r;
        // NOTE: every field gets a value before any conditional update, so the
        // combinational result is fully specified and no latch is inferred.
        r.blocked = 1'b0;
        r.data    = rf_data;
        if (wb_en && wb_addr == addr) begin
            r.data = wb_data;
        end
        for (int k = 7; k >= 1; k--) begin
            if (st[3'(k)].reg_wr && st[3'(k)].unit_id != 3'd0 &&
                st[3'(k)].reg_dst == addr) begin
                r.data    = st[3'(k)].result;
                r.blocked = st[3'(k)].latency > 4'(k);
            end
        end
        return r;
    endfunction

    always_comb begin
        stages[1] = bus.packed_result_1stage;
        stages[2] = bus.packed_result_2stage;
        stages[3] = bus.packed_result_3stage;
        stages[4] = bus.packed_result_4stage;
        stages[5] = bus.packed_result_5stage;
        stages[6] = bus.packed_result_6stage;
        stages[7] = bus.packed_result_7stage;
    end

    always_comb begin
        op_a = resolve(bus.req_ra_addr, bus.rf_ra_data, stages,
                       bus.wb_en, bus.wb_addr, bus.wb_data);
        op_b = resolve(bus.req_rb_addr, bus.rf_rb_data, stages,
                       bus.wb_en, bus.wb_addr, bus.wb_data);
        op_c = resolve(bus.req_rc_addr, bus.rf_rc_data, stages,
                       bus.wb_en, bus.wb_addr, bus.wb_data);
    end

    assign bus.hazard    = bus.req_valid && (op_a.blocked || op_b.blocked || op_c.blocked);
    // The output slot can take a new entry when empty or when it drains this cycle.
    assign bus.req_ready = !bus.hazard && (!out_valid_q || bus.out_ready);
    assign accept        = bus.req_valid && bus.req_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the operand registers are plain flops (not a memory array)
            // and are cleared so execute never sees stale data after reset.
            state       <= EMPTY;
            out_valid_q <= 1'b0;
            ra_q        <= '0;
            rb_q        <= '0;
            rc_q        <= '0;
            stall_q     <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state       <= FULL;
                        out_valid_q <= 1'b1;
                    end
                end
                FULL: begin
                    // Drain with a simultaneous accept stays FULL: no bubble.
                    if (bus.out_ready && !accept) begin
                        state       <= EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    out_valid_q <= 1'b0;
                end
            endcase

            if (accept) begin
                ra_q <= op_a.data;
                rb_q <= op_b.data;
                rc_q <= op_c.data;
            end

            if (bus.hazard && stall_q != 16'hFFFF) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_ra_data = ra_q;
    assign bus.out_rb_data = rb_q;
    assign bus.out_rc_data = rc_q;
    assign bus.stall_count = stall_q;

endmodule

// File: tb/tb_operand_fwd_unit.sv
// ---------------------------------------------------------------------------
// tb_operand_fwd_unit
// Directed scenarios plus randomized traffic, all checked against a
// behavioural model: operands are found by a first-match search over the
// pipeline stages, and the output slot is tracked as a valid flag plus data.
// ---------------------------------------------------------------------------
module tb_operand_fwd_unit;

    logic clk = 1'b0;
    logic rst = 1'b0;

    operand_fwd_unit_if bus ();
    logic [0:142] stg [1:7];

    assign bus.packed_result_1stage = stg[1];
    assign bus.packed_result_2stage = stg[2];
    assign bus.packed_result_3stage = stg[3];
    assign bus.packed_result_4stage = stg[4];
    assign bus.packed_result_5stage = stg[5];
    assign bus.packed_result_6stage = stg[6];
    assign bus.packed_result_7stage = stg[7];

    operand_fwd_unit dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    bit           exp_valid;
    logic [0:127] exp_ra, exp_rb, exp_rc;
    int           exp_stall;

    function automatic logic [0:142] mk(input logic [2:0] u, input logic [0:127] r,
                                        input logic [6:0] d, input logic [3:0] l,
                                        input logic w);
        return {u, r, d, l, w};
    endfunction

    function automatic logic [0:127] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // First match from the youngest stage decides; WB, then RF, otherwise.
    function automatic void ref_operand(input logic [0:6] addr, input logic [0:127] rf,
                                        output logic [0:127] data, output bit blocked);
        logic [0:142] p;
        blocked = 1'b0;
        data    = rf;
        for (int k = 1; k <= 7; k++) begin
            p = stg[k];
            if (p[142] == 1'b1 && p[0:2] != 3'd0 && p[131:137] == addr) begin
                data    = p[3:130];
                blocked = int'(p[138:141]) > k;
                return;
            end
        end
        if (bus.wb_en && bus.wb_addr == addr) data = bus.wb_data;
    endfunction

    function automatic bit ref_hazard();
        logic [0:127] d;
        bit ba, bb, bc;
        ref_operand(bus.req_ra_addr, bus.rf_ra_data, d, ba);
        ref_operand(bus.req_rb_addr, bus.rf_rb_data, d, bb);
        ref_operand(bus.req_rc_addr, bus.rf_rc_data, d, bc);
        return bus.req_valid && (ba || bb || bc);
    endfunction

    function automatic bit ref_ready();
        return !ref_hazard() && (!exp_valid || bus.out_ready);
    endfunction

    // Advance the model with the pre-edge inputs, then cross one rising edge.
    task automatic tick();
        logic [0:127] da, db, dc;
        bit ba, bb, bc, haz, acc;
        ref_operand(bus.req_ra_addr, bus.rf_ra_data, da, ba);
        ref_operand(bus.req_rb_addr, bus.rf_rb_data, db, bb);
        ref_operand(bus.req_rc_addr, bus.rf_rc_data, dc, bc);
        haz = bus.req_valid && (ba || bb || bc);
        acc = bus.req_valid && !haz && (!exp_valid || bus.out_ready);
        if (haz && exp_stall < 65535) exp_stall++;
        if (acc) begin
            exp_valid = 1'b1;
            exp_ra = da; exp_rb = db; exp_rc = dc;
        end else if (exp_valid && bus.out_ready) begin
            exp_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stages();
        for (int k = 1; k <= 7; k++) stg[k] = '0;
    endtask

    task automatic shift_stages();
        for (int k = 7; k >= 2; k--) stg[k] = stg[k-1];
        stg[1] = '0;
    endtask

    task automatic test_reset();
        clear_stages();
        bus.req_valid = 1'b0; bus.out_ready = 1'b0; bus.wb_en = 1'b0;
        bus.req_ra_addr = '0; bus.req_rb_addr = '0; bus.req_rc_addr = '0;
        bus.rf_ra_data = '0; bus.rf_rb_data = '0; bus.rf_rc_data = '0;
        bus.wb_addr = '0; bus.wb_data = '0;
        exp_valid = 1'b0; exp_ra = '0; exp_rb = '0; exp_rc = '0; exp_stall = 0;
        rst = 1'b0;
        #12;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_ra_data !== 128'd0 || bus.out_rb_data !== 128'd0 || bus.out_rc_data !== 128'd0) begin
            n_fail++; $display("FAIL reset_out_data: got %h %h %h want 0", bus.out_ra_data, bus.out_rb_data, bus.out_rc_data); end
        n_cmp++; if (bus.stall_count !== 16'd0) begin n_fail++; $display("FAIL reset_stall_count: got %h want 0", bus.stall_count); end
        n_cmp++; if (bus.hazard !== 1'b0) begin n_fail++; $display("FAIL reset_hazard: got %b want 0", bus.hazard); end
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_stage1_fwd();
        logic [0:127] a5;
        a5 = {16{8'hA5}};
        clear_stages();
        stg[1] = mk(3'b100, a5, 7'd10, 4'd1, 1'b1);
        bus.req_ra_addr = 7'd10; bus.req_rb_addr = 7'd11; bus.req_rc_addr = 7'd12;
        bus.rf_ra_data = 128'd7; bus.rf_rb_data = 128'd8; bus.rf_rc_data = 128'd9;
        bus.req_valid = 1'b1; bus.out_ready = 1'b1;
        #1;
        n_cmp++; if (bus.req_ready !== 1'b1 || bus.hazard !== 1'b0) begin
            n_fail++; $display("FAIL stage1_ready: got ready=%b hazard=%b want 1/0", bus.req_ready, bus.hazard); end
        tick();
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_ra_data !== a5) begin
            n_fail++; $display("FAIL stage1_fwd: got v=%b %h want 1 %h", bus.out_valid, bus.out_ra_data, a5); end
        n_cmp++; if (bus.out_rb_data !== 128'd8 || bus.out_rc_data !== 128'd9) begin
            n_fail++; $display("FAIL stage1_rf_others: got %h %h want 8 9", bus.out_rb_data, bus.out_rc_data); end
        bus.req_valid = 1'b0;
        tick();
    endtask

    task automatic test_hazard_stall();
        logic [0:127] young, old;
        int base;
        young = rnd128(); old = rnd128();
        clear_stages();
        stg[2] = mk(3'd1, young, 7'd5, 4'd6, 1'b1);
        stg[5] = mk(3'd2, old,   7'd5, 4'd2, 1'b1);
        bus.req_ra_addr = 7'd1; bus.req_rb_addr = 7'd5; bus.req_rc_addr = 7'd2;
        bus.req_valid = 1'b1; bus.out_ready = 1'b1;
        base = exp_stall;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_cmp++; if (bus.hazard !== 1'b1 || bus.req_ready !== 1'b0) begin
                n_fail++; $display("FAIL hazard_cycle%0d: got hazard=%b ready=%b want 1/0", c, bus.hazard, bus.req_ready); end
            tick();
            shift_stages();
        end
        #1;
        n_cmp++; if (bus.hazard !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL hazard_release: got hazard=%b ready=%b want 0/1", bus.hazard, bus.req_ready); end
        n_cmp++; if (bus.stall_count !== 16'(base + 4)) begin
            n_fail++; $display("FAIL hazard_stall_count: got %0d want %0d", bus.stall_count, base + 4); end
        tick();
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_rb_data !== young) begin
            n_fail++; $display("FAIL hazard_fwd_data: got v=%b %h want 1 %h", bus.out_valid, bus.out_rb_data, young); end
        bus.req_valid = 1'b0;
        clear_stages();
        tick();
    endtask

    task automatic test_wb();
        clear_stages();
        bus.wb_en = 1'b1; bus.wb_addr = 7'd3; bus.wb_data = 128'h1;
        bus.rf_rc_data = 128'h2; bus.req_rc_addr = 7'd3;
        bus.req_ra_addr = 7'd3; bus.rf_ra_data = 128'h55;
        bus.req_rb_addr = 7'd4; bus.rf_rb_data = 128'h66;
        bus.req_valid = 1'b1; bus.out_ready = 1'b1;
        tick();
        n_cmp++; if (bus.out_rc_data !== 128'h1) begin
            n_fail++; $display("FAIL wb_fwd: got %h want 1", bus.out_rc_data); end
        n_cmp++; if (bus.out_ra_data !== bus.out_rc_data || bus.out_rb_data !== 128'h66) begin
            n_fail++; $display("FAIL wb_same_addr: got %h %h want 1 66", bus.out_ra_data, bus.out_rb_data); end
        bus.req_valid = 1'b0; bus.wb_en = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [0:127] held, nxt;
        clear_stages();
        bus.req_ra_addr = 7'd20; bus.req_rb_addr = 7'd21; bus.req_rc_addr = 7'd22;
        held = rnd128();
        bus.rf_ra_data = held; bus.req_valid = 1'b1; bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            bus.rf_ra_data = rnd128();
            #1;
            n_cmp++; if (bus.req_ready !== 1'b0) begin
                n_fail++; $display("FAIL hold_ready%0d: got %b want 0", c, bus.req_ready); end
            tick();
            n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_ra_data !== held) begin
                n_fail++; $display("FAIL hold_stable%0d: got v=%b %h want 1 %h", c, bus.out_valid, bus.out_ra_data, held); end
        end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            nxt = rnd128();
            bus.rf_ra_data = nxt;
            #1;
            n_cmp++; if (bus.req_ready !== 1'b1) begin
                n_fail++; $display("FAIL b2b_ready%0d: got %b want 1", c, bus.req_ready); end
            tick();
            n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_ra_data !== nxt) begin
                n_fail++; $display("FAIL b2b_data%0d: got v=%b %h want 1 %h", c, bus.out_valid, bus.out_ra_data, nxt); end
        end
        bus.req_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int k = 1; k <= 7; k++) begin
                if ($urandom_range(0, 1) == 1)
                    stg[k] = mk(3'($urandom_range(0, 7)), rnd128(), 7'($urandom_range(0, 7)),
                                4'($urandom_range(0, 9)), 1'($urandom_range(0, 1)));
                else
                    stg[k] = '0;
            end
            bus.req_ra_addr = 7'($urandom_range(0, 7));
            bus.req_rb_addr = ($urandom_range(0, 3) == 0) ? bus.req_ra_addr : 7'($urandom_range(0, 7));
            bus.req_rc_addr = 7'($urandom_range(0, 7));
            bus.rf_ra_data = rnd128(); bus.rf_rb_data = rnd128(); bus.rf_rc_data = rnd128();
            bus.wb_en = 1'($urandom_range(0, 1));
            bus.wb_addr = 7'($urandom_range(0, 7));
            bus.wb_data = rnd128();
            bus.req_valid = ($urandom_range(0, 9) < 8);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            #1;
            n_cmp++; if (bus.hazard !== ref_hazard() || bus.req_ready !== ref_ready()) begin
                n_fail++; $display("FAIL rnd_comb%0d: got hazard=%b ready=%b want %b/%b",
                                   c, bus.hazard, bus.req_ready, ref_hazard(), ref_ready()); end
            tick();
            n_cmp++; if (bus.out_valid !== exp_valid || bus.out_ra_data !== exp_ra ||
                         bus.out_rb_data !== exp_rb || bus.out_rc_data !== exp_rc) begin
                n_fail++; $display("FAIL rnd_out%0d: got v=%b %h %h %h want v=%b %h %h %h", c,
                                   bus.out_valid, bus.out_ra_data, bus.out_rb_data, bus.out_rc_data,
                                   exp_valid, exp_ra, exp_rb, exp_rc); end
            n_cmp++; if (bus.stall_count !== 16'(exp_stall)) begin
                n_fail++; $display("FAIL rnd_stall%0d: got %0d want %0d", c, bus.stall_count, exp_stall); end
        end
        bus.req_valid = 1'b0; bus.wb_en = 1'b0;
        clear_stages();
        tick();
    endtask

    task automatic test_stall_saturation();
        clear_stages();
        stg[1] = mk(3'd1, 128'd0, 7'd9, 4'd15, 1'b1);
        bus.req_ra_addr = 7'd9; bus.req_valid = 1'b1; bus.out_ready = 1'b1;
        #1;
        n_cmp++; if (bus.hazard !== 1'b1) begin
            n_fail++; $display("FAIL sat_hazard: got %b want 1", bus.hazard);
        end else begin
            while (exp_stall < 16'hFFFE) tick();
            n_cmp++; if (bus.stall_count !== 16'hFFFE) begin
                n_fail++; $display("FAIL sat_preset: got %h want fffe", bus.stall_count); end
            repeat (3) tick();
            n_cmp++; if (bus.stall_count !== 16'hFFFF) begin
                n_fail++; $display("FAIL sat_stall_count: got %h want ffff", bus.stall_count); end
        end
        bus.req_valid = 1'b0;
        clear_stages();
        tick();
    endtask

    task automatic test_reset_mid();
        bus.req_ra_addr = 7'd30; bus.rf_ra_data = rnd128();
        bus.req_valid = 1'b1; bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        tick();
        n_cmp++; if (bus.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL mid_setup_valid: got %b want 1", bus.out_valid); end
        #2 rst = 1'b0;
        #1;
        exp_valid = 1'b0; exp_ra = '0; exp_rb = '0; exp_rc = '0; exp_stall = 0;
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.stall_count !== 16'd0) begin
            n_fail++; $display("FAIL mid_reset_async: got v=%b stall=%h want 0/0", bus.out_valid, bus.stall_count); end
        n_cmp++; if (bus.out_ra_data !== 128'd0 || bus.out_rb_data !== 128'd0 || bus.out_rc_data !== 128'd0) begin
            n_fail++; $display("FAIL mid_reset_data: got %h %h %h want 0", bus.out_ra_data, bus.out_rb_data, bus.out_rc_data); end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_held: got %b want 0", bus.out_valid); end
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL release_no_early_accept: got %b want 0", bus.out_valid); end
        tick();
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_ra_data !== exp_ra) begin
            n_fail++; $display("FAIL release_first_accept: got v=%b %h want 1 %h", bus.out_valid, bus.out_ra_data, exp_ra); end
        bus.req_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_stage1_fwd();
        test_hazard_stall();
        test_wb();
        test_back_to_back();
        test_random();
        test_stall_saturation();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_fwd_unit.md
OPERAND_FWD_UNIT -- requirements
Module: operand_fwd_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have ports req_valid (input, 1) and req_ready (output, 1): operand-request handshake from issue.
REQ-004 SHALL have ports req_ra_addr, req_rb_addr and req_rc_addr, input, [0:6] each: source register numbers.
REQ-005 SHALL have ports rf_ra_data, rf_rb_data and rf_rc_data, input, [0:127] each: register-file read data for the current request addresses.
REQ-006 SHALL have ports packed_result_1stage … packed_result_7stage, input, [0:142] each, with fields [0:2] unit_id, [3:130] result, [131:137] reg_dst, [138:141] latency, [142] reg_wr.
REQ-007 SHALL have ports wb_addr (input, [0:6]), wb_data (input, [0:127]) and wb_en (input, 1): writeback-stage register write.
REQ-008 SHALL have ports out_valid (output, 1) and out_ready (input, 1): handshake to the execute stage.
REQ-009 SHALL have ports out_ra_data, out_rb_data and out_rc_data, output, [0:127] each: resolved operands.
REQ-010 SHALL have port hazard, output, 1 bit: combinational; current request blocked by a not-yet-ready producer.
REQ-011 SHALL have port stall_count, output, [0:15]: count of stalled request cycles.

Function
REQ-012 SHALL treat stage k (k=1..7) as matching operand X when reg_wr=1, unit_id!=0 and reg_dst==X_addr.
REQ-013 SHALL treat a matching stage k as ready when latency<=k, and as not ready otherwise.
REQ-014 SHALL resolve each operand by priority: youngest matching stage (1 first, then 2 … 7), then WB (wb_en=1 and wb_addr match), then rf data.
REQ-015 SHALL assert hazard when req_valid=1 and any operand's highest-priority match is not ready; an older ready match SHALL NOT bypass a younger not-ready match.
REQ-016 SHALL drive req_ready = !hazard && (!out_valid || out_ready), combinationally.
REQ-017 SHALL, on accept (req_valid && req_ready), register the three resolved operands into out_*_data and set out_valid=1 at the next edge (1-cycle latency).
REQ-018 SHALL clear out_valid when out_valid && out_ready && no accept occurs in that cycle; SHALL reload without a bubble when an accept and a drain coincide.
REQ-019 SHALL hold out_*_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-020 SHALL implement FSM states with these transitions:
- EMPTY: out_valid=0.
- FULL: out_valid=1.
- EMPTY->FULL on accept.
- FULL->EMPTY on drain without accept.
- FULL->FULL on hold or on drain+accept.
REQ-021 SHALL increment stall_count by 1 each cycle with req_valid && hazard, saturating at 16'hFFFF.
REQ-022 SHALL resolve requests with identical addresses (e.g. ra=rb) independently, yielding identical data.
REQ-023 SHALL re-evaluate hazard every cycle with no internal memory of prior hazards.

Reset
REQ-024 SHALL, while rst=0, force out_valid=0, out_ra_data/out_rb_data/out_rc_data=0, stall_count=0 and FSM=EMPTY, asynchronously.
REQ-025 SHALL discard a request pending at reset assertion; the first accept after reset release SHALL occur no earlier than the first rising edge with rst=1.

Verification
REQ-026 SHALL verify: stage1 = {unit 3'b100, result 128'hA5…A5, dst 7'd10, latency 4'd1, wr 1}, req_ra_addr=10 -> out_ra_data=128'hA5…A5 one cycle after accept.
REQ-027 SHALL verify: stage2 dst 5 latency 6, stage5 dst 5 latency 2 ready, req_rb_addr=5 -> hazard=1 and req_ready=0 for 4 cycles, with stall_count incremented by 4; accept occurs when the first producer reaches stage 6.
REQ-028 SHALL verify: no stage match, wb_en=1, wb_addr=3, wb_data=128'h1, rf_rc_data=128'h2, req_rc_addr=3 -> out_rc_data=128'h1.
REQ-029 SHALL verify: out_ready=0 for 3 cycles with req_valid=1 -> req_ready=0 and outputs stable; out_ready=1 -> back-to-back accepts with no bubble.
REQ-030 SHALL verify: stall_count preset to 16'hFFFE with 3 hazard cycles -> stall_count=16'hFFFF.
REQ-031 SHALL verify: rst=0 asserted mid-transfer with out_valid=1 -> out_valid=0, out data=0 and stall_count=0 immediately, before any clock edge.
